// File: rtl/mar_burst_if.sv
// -----------------------------------------------------------------------------
// mar_burst_if -- bus bundle for the mar_burst memory address register.
//
// Signals:
//   in          packed load sources, channel k at [k*ADDR_W +: ADDR_W]
//   re          per-channel load enable
//   inc         single-step increment request
//   burst_start start an auto-increment burst from the current out1
//   burst_len   number of increments in a burst
//   out1        registered address
//   busy        high while the register is bursting
//   done        one-cycle pulse after the last burst increment
//   err         sticky bound error (only when MAR_BOUND_CHECK_EN is defined)
//
// Modports: master drives the requests, slave is the address register.
// -----------------------------------------------------------------------------
interface mar_burst_if #(
  parameter int ADDR_W  = 15,
  parameter int NUM_SRC = 2,
  parameter int LEN_W   = 4
);
  logic [NUM_SRC*ADDR_W-1:0] in;
  logic [NUM_SRC-1:0]        re;
  logic                      inc;
  logic                      burst_start;
  logic [LEN_W-1:0]          burst_len;
  logic [ADDR_W-1:0]         out1;
  logic                      busy;
  logic                      done;
`ifdef MAR_BOUND_CHECK_EN
  logic                      err;
`endif

  modport master (
    output in, re, inc, burst_start, burst_len,
`ifdef MAR_BOUND_CHECK_EN
    input  err,
`endif
    input  out1, busy, done
  );

  modport slave (
    input  in, re, inc, burst_start, burst_len,
`ifdef MAR_BOUND_CHECK_EN
    output err,
`endif
    output out1, busy, done
  );
endinterface

// File: rtl/mar_burst.sv
// -----------------------------------------------------------------------------
// mar_burst -- memory address register with multi-source load, single-step
// increment and an auto-increment burst mode.
//
// Ports:
//   clk  single clock, all state updates on the rising edge
//   rst  asynchronous, active-high reset
//   bus  mar_burst_if.slave: in/re/inc/burst_start/burst_len in,
//        out1/busy/done (and err) out
//
// Optional feature: define MAR_BOUND_CHECK_EN to add the sticky err output,
// set by an out-of-range load (value > ADDR_TOP) or an increment that wraps
// from ADDR_TOP to 0. Without the macro err and its logic are absent.
//
// Priority in IDLE: load (highest re index wins) > inc > burst_start.
// While bursting all requests are ignored.
// -----------------------------------------------------------------------------
module mar_burst #(
  parameter int ADDR_W   = 15,
  parameter int NUM_SRC  = 2,
  parameter int LEN_W    = 4,
  parameter int ADDR_TOP = 2**ADDR_W-1
) (
  input  logic       clk,
  input  logic       rst,
  mar_burst_if.slave bus
);

  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(ADDR_TOP);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] out1_q, out1_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              done_q, done_d;
  logic              load_hit;
  logic [ADDR_W-1:0] load_val;
`ifdef MAR_BOUND_CHECK_EN
  logic              err_q, err_d;
`endif

  // Wrapping increment: ADDR_TOP is the last legal address.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == TOP) ? '0 : a + ADDR_W'(1);
  endfunction

  // Ascending scan so the highest asserted channel overrides lower ones.
  always_comb begin
    load_hit = 1'b0;
    load_val = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.re[k]) begin
        load_hit = 1'b1;
        load_val = bus.in[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out1_d  = out1_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef MAR_BOUND_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_hit) begin
          out1_d = load_val;
`ifdef MAR_BOUND_CHECK_EN
          // Widened compare: the load is performed even when out of range.
          if ({1'b0, load_val} > {1'b0, TOP}) err_d = 1'b1;
`endif
        end else if (bus.inc) begin
          out1_d = next_addr(out1_q);
`ifdef MAR_BOUND_CHECK_EN
          if (out1_q == TOP) err_d = 1'b1;
`endif
        end else if (bus.burst_start) begin
          // A zero-length burst completes at once without entering BURST.
          if (bus.burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d   = bus.burst_len;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        out1_d = next_addr(out1_q);
`ifdef MAR_BOUND_CHECK_EN
        if (out1_q == TOP) err_d = 1'b1;
`endif
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out1_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out1_q  <= out1_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef MAR_BOUND_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`endif

  assign bus.out1 = out1_q;
  assign bus.busy = (state_q == BURST);
  assign bus.done = done_q;

endmodule

// File: tb/tb_mar_burst.sv
// -----------------------------------------------------------------------------
// tb_mar_burst -- self-checking bench for mar_burst. Two instances share the
// same stimulus: dut_a with the default ADDR_TOP and dut_b with ADDR_TOP=100.
// Expected results are pushed to per-instance queues when stimulus is driven
// and popped after the following rising edge.
// -----------------------------------------------------------------------------
module tb_mar_burst;

  typedef struct packed {
    logic [14:0] out1;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]  re_v  = '0;
  logic [14:0] c0_v  = '0;
  logic [14:0] c1_v  = '0;
  logic        inc_v = 1'b0;
  logic        bs_v  = 1'b0;
  logic [3:0]  len_v = '0;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int   m_top [2] = '{32767, 100};
  int   m_out [2];
  int   m_rem [2];
  logic m_busy[2];
  logic m_done[2];
  logic m_err [2];

  mar_burst_if #(.ADDR_W(15), .NUM_SRC(2), .LEN_W(4)) ifa ();
  mar_burst_if #(.ADDR_W(15), .NUM_SRC(2), .LEN_W(4)) ifb ();

  mar_burst #(.ADDR_W(15), .NUM_SRC(2), .LEN_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mar_burst #(.ADDR_W(15), .NUM_SRC(2), .LEN_W(4), .ADDR_TOP(100)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  assign ifa.in = {c1_v, c0_v};
  assign ifb.in = {c1_v, c0_v};
  assign ifa.re = re_v;
  assign ifb.re = re_v;
  assign ifa.inc = inc_v;
  assign ifb.inc = inc_v;
  assign ifa.burst_start = bs_v;
  assign ifb.burst_start = bs_v;
  assign ifa.burst_len = len_v;
  assign ifb.burst_len = len_v;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d] = 0; m_rem[d] = 0; m_busy[d] = 1'b0; m_done[d] = 1'b0; m_err[d] = 1'b0;
    end
  endtask

  function automatic exp_t model_step(input int d);
    exp_t e;
    int   v;
    m_done[d] = 1'b0;
    if (m_busy[d]) begin
      if (m_out[d] == m_top[d]) begin
        m_out[d] = 0;
        m_err[d] = 1'b1;
      end else begin
        m_out[d] = m_out[d] + 1;
      end
      m_rem[d] = m_rem[d] - 1;
      if (m_rem[d] == 0) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b1;
      end
    end else if (re_v != 2'b00) begin
      v = re_v[1] ? int'(c1_v) : int'(c0_v);
      m_out[d] = v;
      if (v > m_top[d]) m_err[d] = 1'b1;
    end else if (inc_v) begin
      if (m_out[d] == m_top[d]) begin
        m_out[d] = 0;
        m_err[d] = 1'b1;
      end else begin
        m_out[d] = m_out[d] + 1;
      end
    end else if (bs_v) begin
      if (len_v == 0) begin
        m_done[d] = 1'b1;
      end else begin
        m_rem[d]  = int'(len_v);
        m_busy[d] = 1'b1;
      end
    end
    e.out1 = m_out[d][14:0];
    e.busy = m_busy[d];
    e.done = m_done[d];
    e.err  = m_err[d];
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    if (q_a.size() == 0) begin
      check("queue_a_empty", 32'd0, 32'd1);
    end else begin
      e = q_a.pop_front();
      check("a.out1", 32'(ifa.out1), 32'(e.out1));
      check("a.busy", 32'(ifa.busy), 32'(e.busy));
      check("a.done", 32'(ifa.done), 32'(e.done));
`ifdef MAR_BOUND_CHECK_EN
      check("a.err", 32'(ifa.err), 32'(e.err));
`endif
    end
    if (q_b.size() == 0) begin
      check("queue_b_empty", 32'd0, 32'd1);
    end else begin
      e = q_b.pop_front();
      check("b.out1", 32'(ifb.out1), 32'(e.out1));
      check("b.busy", 32'(ifb.busy), 32'(e.busy));
      check("b.done", 32'(ifb.done), 32'(e.done));
`ifdef MAR_BOUND_CHECK_EN
      check("b.err", 32'(ifb.err), 32'(e.err));
`endif
    end
  endtask

  // Drive one cycle of stimulus on the falling edge, sample after the rise.
  task automatic step(input logic [1:0] re, input logic [14:0] c0, input logic [14:0] c1,
                      input logic inc, input logic bs, input logic [3:0] len);
    @(negedge clk);
    re_v = re; c0_v = c0; c1_v = c1; inc_v = inc; bs_v = bs; len_v = len;
    q_a.push_back(model_step(0));
    q_b.push_back(model_step(1));
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle();
    step(2'b00, 15'h0, 15'h0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    model_reset();

    // Reset state while rst is held.
    #3;
    check("rst.a.out1", 32'(ifa.out1), 32'd0);
    check("rst.a.busy", 32'(ifa.busy), 32'd0);
    check("rst.a.done", 32'(ifa.done), 32'd0);
    check("rst.b.out1", 32'(ifb.out1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Highest channel wins.
    step(2'b11, 15'h0005, 15'h7FFF, 1'b0, 1'b0, 4'd0);
    check("ch1_wins", 32'(ifa.out1), 32'h7FFF);
    // Increment wraps at the default top.
    step(2'b00, 15'h0, 15'h0, 1'b1, 1'b0, 4'd0);
    check("wrap_default", 32'(ifa.out1), 32'h0);

    // Burst of 4 from 3.
    step(2'b01, 15'h0003, 15'h0, 1'b0, 1'b0, 4'd0);
    step(2'b00, 15'h0, 15'h0, 1'b0, 1'b1, 4'd4);
    check("burst_accept_out1", 32'(ifa.out1), 32'd3);
    busy_cnt = int'(ifa.busy);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      busy_cnt += int'(ifa.busy);
      if (ifa.done) begin
        done_cnt++;
        check("done_out1", 32'(ifa.out1), 32'd7);
      end
    end
    check("burst_busy_cycles", 32'(busy_cnt), 32'd4);
    check("burst_done_count", 32'(done_cnt), 32'd1);

    // Load beats inc beats burst_start.
    step(2'b01, 15'h0020, 15'h0, 1'b1, 1'b1, 4'd3);
    check("prio_out1", 32'(ifa.out1), 32'h20);
    check("prio_busy", 32'(ifa.busy), 32'd0);
    idle();
    check("prio_no_done", 32'(ifa.done), 32'd0);

    // Zero-length burst.
    step(2'b00, 15'h0, 15'h0, 1'b0, 1'b1, 4'd0);
    check("len0_done", 32'(ifa.done), 32'd1);
    check("len0_out1", 32'(ifa.out1), 32'h20);
    idle();

    // ADDR_TOP=100 wrap on dut_b, out-of-range load and wrapping burst.
    step(2'b01, 15'd100, 15'h0, 1'b0, 1'b0, 4'd0);
    step(2'b00, 15'h0, 15'h0, 1'b1, 1'b0, 4'd0);
    check("wrap_top100", 32'(ifb.out1), 32'd0);
`ifdef MAR_BOUND_CHECK_EN
    check("err_set_b", 32'(ifb.err), 32'd1);
`endif
    step(2'b10, 15'h0, 15'd120, 1'b0, 1'b0, 4'd0);
    check("oor_load_b", 32'(ifb.out1), 32'd120);
    step(2'b01, 15'd99, 15'h0, 1'b0, 1'b0, 4'd0);
    step(2'b00, 15'h0, 15'h0, 1'b0, 1'b1, 4'd3);
    // Requests during a burst are ignored.
    step(2'b11, 15'h1234, 15'h4321, 1'b1, 1'b1, 4'd9);
    step(2'b00, 15'h0, 15'h0, 1'b1, 1'b0, 4'd0);
    step(2'b01, 15'h0555, 15'h0, 1'b0, 1'b1, 4'd2);
    check("burst_wrap_b", 32'(ifb.out1), 32'd1);
    idle();

    // Asynchronous reset in the middle of a burst at out1=0x10.
    step(2'b01, 15'h000E, 15'h0, 1'b0, 1'b0, 4'd0);
    step(2'b00, 15'h0, 15'h0, 1'b0, 1'b1, 4'd5);
    idle();
    idle();
    check("pre_rst_out1", 32'(ifa.out1), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out1", 32'(ifa.out1), 32'd0);
    check("async_rst_busy", 32'(ifa.busy), 32'd0);
    check("async_rst_b_out1", 32'(ifb.out1), 32'd0);
`ifdef MAR_BOUND_CHECK_EN
    check("async_rst_b_err", 32'(ifb.err), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
    end
    // First edge after reset loads normally.
    step(2'b01, 15'h0042, 15'h0, 1'b0, 1'b0, 4'd0);
    check("post_rst_load", 32'(ifa.out1), 32'h42);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0]  re_r;
      logic [14:0] a0, a1;
      r = $urandom_range(0, 9);
      re_r = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      a0 = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 110)) : 15'($urandom);
      a1 = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 110)) : 15'($urandom);
      step(re_r, a0, a1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
